// File: rtl/i2c_master_byte_ctrl_if.sv
// Host and bit-controller signal bundle for the I2C byte sequencer.
// master: the byte controller; slave: the host / bit-controller side.
interface i2c_master_byte_ctrl_if #(
  parameter int CMD_W = 4
);
  logic             start;
  logic             stop;
  logic             read;
  logic             write;
  logic             ack_in;
  logic [7:0]       din;
  logic             cmd_ack;
  logic             ack_out;
  logic [7:0]       dout;
  logic             i2c_al;
  logic [CMD_W-1:0] core_cmd;
  logic             core_txd;
  logic             core_ack;
  logic             core_rxd;
  logic             core_al;

  modport master (
    input  start, stop, read, write, ack_in, din,
    input  core_ack, core_rxd, core_al,
    output cmd_ack, ack_out, dout, i2c_al,
    output core_cmd, core_txd
  );

  modport slave (
    output start, stop, read, write, ack_in, din,
    output core_ack, core_rxd, core_al,
    input  cmd_ack, ack_out, dout, i2c_al,
    input  core_cmd, core_txd
  );
endinterface

// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master: host byte requests to START/WRITE/READ/STOP bits.
// Optional per-bit watchdog enabled by defining I2C_BYTE_TIMEOUT_EN.
module i2c_master_byte_ctrl #(
  parameter int CMD_W = 4
`ifdef I2C_BYTE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic clk,
  input  logic rst,
`ifdef I2C_BYTE_TIMEOUT_EN
  output logic timeout,
`endif
  i2c_master_byte_ctrl_if.master bus
);

  localparam logic [CMD_W-1:0] C_NOP   = CMD_W'(4'b0000);
  localparam logic [CMD_W-1:0] C_START = CMD_W'(4'b0001);
  localparam logic [CMD_W-1:0] C_STOP  = CMD_W'(4'b0010);
  localparam logic [CMD_W-1:0] C_WRITE = CMD_W'(4'b0100);
  localparam logic [CMD_W-1:0] C_READ  = CMD_W'(4'b1000);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WRITE,
    S_READ,
    S_ACK,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [CMD_W-1:0] r_cmd;
  logic             r_txd;
  logic             r_cmd_ack;
  logic             r_ack_out;
  logic [7:0]       r_sr;
  logic [2:0]       r_cnt;
  logic             r_al;

  state_t           w_state_n;
  logic [CMD_W-1:0] w_cmd_n;
  logic             w_txd_n;
  logic             w_cmd_ack_n;
  logic             w_ack_out_n;
  logic [7:0]       w_sr_n;
  logic [2:0]       w_cnt_n;
  logic             w_al_n;

  logic             w_go;
  logic             w_cnt_done;
  logic [7:0]       w_sr_shift;
  logic             w_abort;

  assign w_go       = (bus.read | bus.write | bus.stop) & ~r_cmd_ack;
  assign w_cnt_done = (r_cnt == 3'd0);
  assign w_sr_shift = {r_sr[6:0], bus.core_rxd};

`ifdef I2C_BYTE_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_timeout;
  logic        w_to_hit;

  assign w_to_hit = (r_state != S_IDLE) &&
                    (r_to_cnt == 16'(TIMEOUT_CYCLES));
  assign w_abort  = bus.core_al | w_to_hit;
  assign timeout  = r_timeout;

  // Watchdog restarts whenever the bit controller makes progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt  <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_hit;
      if (r_state == S_IDLE || bus.core_ack || w_cmd_n != r_cmd)
        r_to_cnt <= 16'd0;
      else
        r_to_cnt <= r_to_cnt + 16'd1;
    end
  end
`else
  assign w_abort = bus.core_al;
`endif

  always_comb begin
    w_state_n   = r_state;
    w_cmd_n     = r_cmd;
    w_txd_n     = r_txd;
    w_cmd_ack_n = 1'b0;
    w_ack_out_n = r_ack_out;
    w_sr_n      = r_sr;
    w_cnt_n     = r_cnt;
    w_al_n      = 1'b0;
    if (w_abort) begin
      w_state_n = S_IDLE;
      w_cmd_n   = C_NOP;
      w_al_n    = bus.core_al;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            w_sr_n  = bus.din;
            w_cnt_n = 3'd7;
            w_txd_n = bus.din[7];
            if (bus.start) begin
              w_state_n = S_START;
              w_cmd_n   = C_START;
            end else if (bus.read) begin
              w_state_n = S_READ;
              w_cmd_n   = C_READ;
            end else if (bus.write) begin
              w_state_n = S_WRITE;
              w_cmd_n   = C_WRITE;
            end else begin
              w_state_n = S_STOP;
              w_cmd_n   = C_STOP;
            end
          end
        end
        S_START: begin
          if (bus.core_ack) begin
            w_txd_n = r_sr[7];
            if (bus.read) begin
              w_state_n = S_READ;
              w_cmd_n   = C_READ;
            end else begin
              w_state_n = S_WRITE;
              w_cmd_n   = C_WRITE;
            end
          end
        end
        S_WRITE, S_READ: begin
          if (bus.core_ack) begin
            w_sr_n = w_sr_shift;
            if (w_cnt_done) begin
              w_state_n = S_ACK;
              if (r_state == S_WRITE) begin
                w_cmd_n = C_READ;
              end else begin
                w_cmd_n = C_WRITE;
                w_txd_n = bus.ack_in;
              end
            end else begin
              w_cnt_n = r_cnt - 3'd1;
              w_txd_n = w_sr_shift[7];
            end
          end
        end
        S_ACK: begin
          if (bus.core_ack) begin
            w_ack_out_n = bus.core_rxd;
            if (bus.stop) begin
              w_state_n = S_STOP;
              w_cmd_n   = C_STOP;
            end else begin
              w_state_n   = S_IDLE;
              w_cmd_n     = C_NOP;
              w_cmd_ack_n = 1'b1;
            end
          end
        end
        S_STOP: begin
          if (bus.core_ack) begin
            w_state_n   = S_IDLE;
            w_cmd_n     = C_NOP;
            w_cmd_ack_n = 1'b1;
          end
        end
        default: begin
          w_state_n = S_IDLE;
          w_cmd_n   = C_NOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cmd     <= C_NOP;
      r_txd     <= 1'b0;
      r_cmd_ack <= 1'b0;
      r_ack_out <= 1'b0;
      r_sr      <= 8'd0;
      r_cnt     <= 3'd0;
      r_al      <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cmd     <= w_cmd_n;
      r_txd     <= w_txd_n;
      r_cmd_ack <= w_cmd_ack_n;
      r_ack_out <= w_ack_out_n;
      r_sr      <= w_sr_n;
      r_cnt     <= w_cnt_n;
      r_al      <= w_al_n;
    end
  end

  assign bus.core_cmd = r_cmd;
  assign bus.core_txd = r_txd;
  assign bus.cmd_ack  = r_cmd_ack;
  assign bus.ack_out  = r_ack_out;
  assign bus.dout     = r_sr;
  assign bus.i2c_al   = r_al;

endmodule

// File: doc/i2c_master_byte_ctrl.md
Name: i2c_master_byte_ctrl

Overview:
Byte-level I2C master sequencer. It sits directly upstream of the I2C bit controller. It turns host byte requests (start/write/read/ack/stop) into a sequence of single-bit commands (START, WRITE, READ, STOP) and serialises or deserialises 8-bit data plus the ACK bit. It collects the bit controller's acknowledge, received-bit and arbitration-lost signals and presents them to the register/host layer as one byte-complete handshake.

Parameters:
CMD_W, 4, width of the bit-command bus. Encodings come from the shared I2C config header: NOP=0000, START=0001, STOP=0010, WRITE=0100, READ=1000.
TIMEOUT_CYCLES, 65535, clk cycles allowed per bit command before abort (only used with the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  generate (repeated) START before the byte
stop  in  1  generate STOP after the byte/ACK
read  in  1  read one byte
write  in  1  write one byte
ack_in  in  1  ACK value driven after a read (0=ACK, 1=NACK)
din  in  8  byte to transmit, MSB first
cmd_ack  out  1  one-cycle pulse: host request complete
ack_out  out  1  ACK bit sampled from the slave after a write
dout  out  8  received byte
i2c_al  out  1  one-cycle pulse: arbitration lost, request aborted
core_cmd  out  4  command to the bit controller
core_txd  out  1  data bit to the bit controller
core_ack  in  1  bit-command complete pulse from the bit controller
core_rxd  in  1  sampled SDA bit from the bit controller
core_al  in  1  arbitration lost from the bit controller
timeout  out  1  bit-command timeout pulse (only with I2C_BYTE_TIMEOUT_EN)

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE, core_cmd=NOP, core_txd=0, cmd_ack=0, ack_out=0, dout=0, i2c_al=0, shift reg=0, bit counter=0.
- go = (read | write | stop) & ~cmd_ack. Host holds its request bits until cmd_ack. If go is asserted on the cycle after cmd_ack, a new transfer starts.
- Shift register sr[7:0]. core_txd = sr[7] in WRITE and START; core_txd = ack_in in ACK after a read. dout = sr.
- Bit counter (3 bit). It loads 7 at transfer start and decrements on each data-bit core_ack. cnt_done = (cnt==0).

IDLE:
- On go: sr<=din, cnt<=7.
- If start: state START, core_cmd=START.
- Else if read: state READ, core_cmd=READ.
- Else if write: state WRITE, core_cmd=WRITE.
- Else: state STOP, core_cmd=STOP.

START:
- On core_ack: go to READ (core_cmd=READ) if read, else WRITE (core_cmd=WRITE).

WRITE / READ:
- On core_ack: sr<={sr[6:0],core_rxd}.
- If cnt_done: state ACK. core_cmd=READ after a write; core_cmd=WRITE after a read (core_txd=ack_in).
- Else: cnt<=cnt-1 and reissue the same command.

ACK:
- On core_ack: ack_out<=core_rxd.
- If stop: state STOP, core_cmd=STOP.
- Else: state IDLE, core_cmd=NOP, cmd_ack=1.

STOP:
- On core_ack: state IDLE, core_cmd=NOP, cmd_ack=1.

Command bus rule:
- core_cmd holds its value until the matching core_ack. It changes only on the cycle after core_ack.
- core_txd is registered and held stable for the whole bit.
- Every core_ack pulse in a non-IDLE state advances the sequence exactly once.
- core_ack in IDLE is ignored.

Abort and priority:
- core_al=1 in any state: next cycle state=IDLE, core_cmd=NOP, cmd_ack=0, i2c_al=1 for one cycle, and sr/cnt are frozen.
- core_al has priority over a simultaneous core_ack.
- Write-only with stop=1 and read=0: START (if requested), 8 bits, ACK, STOP, then one cmd_ack.
- A stop-only request (stop=1, read=0, write=0) issues STOP alone.
- read and write both set: read wins.
- Latency: cmd_ack is asserted exactly 1 clk after the final core_ack.

Optional Feature:
I2C_BYTE_TIMEOUT_EN:
- When defined: a 16-bit counter reloads on every core_cmd change or core_ack and counts while state is not IDLE.
- When the count reaches TIMEOUT_CYCLES, the block aborts exactly like core_al: IDLE, core_cmd=NOP, timeout=1 for one cycle, i2c_al stays 0.
- When not defined: no counter, and the timeout port is absent.

Test Plan:
- Write with start: start=1, write=1, din=8'hA5, bit model acks each command, slave ACK=0. Expect: core_cmd sequence START, WRITE×8 with core_txd=1,0,1,0,0,1,0,1, then READ; one cmd_ack; ack_out=0.
- Read with NACK and stop: read=1, stop=1, ack_in=1, slave bits 8'h3C. Expect: READ×8, WRITE (core_txd=1), STOP; dout=8'h3C; one cmd_ack after the STOP ack.
- Stop-only: stop=1, other requests 0. Expect: core_cmd=STOP, then cmd_ack one clk after core_ack, state IDLE.
- Arbitration loss: core_al=1 during the 4th WRITE bit, on the same cycle as core_ack. Expect: i2c_al pulse, core_cmd=NOP, no cmd_ack, and a new request accepted afterwards.
- Reset mid-read: rst=1 during bit 5 of a read. Expect: all outputs at reset values next cycle and core_cmd=NOP.
- Timeout (macro defined, TIMEOUT_CYCLES=100): no core_ack after WRITE. Expect: timeout pulse at cycle 100, core_cmd=NOP, no cmd_ack.
